// File: rtl/ser_pkg.sv
// ser_pkg: shared types and constants for the serializer
package ser_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic IDLE_LEVEL_DEF = 1'b0;
  function automatic int cnt_w(input int w);
    return $clog2(w) < 1 ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, serial-out with a one-word holding register
module piso_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);
  state_t           state;
  logic [WIDTH-1:0] sreg, hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic             accept;
  assign in_ready = !hold_full && !rst;
  assign accept   = in_valid && in_ready;
  // accept needs !hold_full, so it never collides with a hold drain below
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      sreg      <= '0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end
      if (state == IDLE) begin
        if (hold_full) begin
          sreg      <= hold;
          hold_full <= 1'b0;
          cnt       <= CMAX;
          state     <= SHIFT;
        end
      end else if (en) begin
        if (cnt != '0) begin
          sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
          cnt  <= cnt - CW'(1);
        end else if (hold_full) begin
          sreg      <= hold;
          hold_full <= 1'b0;
          cnt       <= CMAX;
        end else begin
          state <= IDLE;
        end
      end
    end
  end
  assign sout        = (state == SHIFT) ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_LEVEL;
  assign sout_valid  = state == SHIFT;
  assign frame_start = (state == SHIFT) && (cnt == CMAX);
  assign busy        = (state == SHIFT) || hold_full;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed scenarios plus random traffic against a bit-stream scoreboard
module tb_piso_serializer;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, en = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, sout, sout_valid, frame_start, busy;
  logic in_ready2, sout2, sout_valid2, frame_start2, busy2;
  logic [W-1:0] lb, lb2, seq2;
  logic bit_q[$], bit_q2[$];
  int pos = 0;
  bit mon_on = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int cnt, fsn, vn, n;
  always #5 clk = ~clk;
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .en(en), .sout(sout), .sout_valid(sout_valid), .frame_start(frame_start), .busy(busy));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .en(en), .sout(sout2), .sout_valid(sout_valid2), .frame_start(frame_start2), .busy(busy2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [W-1:0] d);
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    check("send_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int k = 0;
    while (busy && k < 100) begin
      step();
      k++;
    end
    check("drain", busy, 0);
  endtask
  // stream model: every accepted word becomes W expected bits, consumed on sout_valid && en
  always @(negedge clk) if (mon_on) begin
    if (rst) begin
      check("ready_in_rst", in_ready, 0);
      bit_q.delete();
      bit_q2.delete();
      pos = 0;
    end else begin
      check("busy", busy, bit_q.size() != 0);
      check("ready", in_ready, !(bit_q.size() > (sout_valid ? W - pos : 0)));
      check("lsb_valid", sout_valid2, sout_valid);
      if (sout_valid) begin
        check("frame_start", frame_start, pos == 0);
        check("lsb_frame_start", frame_start2, pos == 0);
        if (bit_q.size() == 0) check("extra_bit", sout_valid, 0);
        else begin
          check("sout", sout, bit_q[0]);
          check("sout_lsb", sout2, bit_q2[0]);
          if (en) begin
            void'(bit_q.pop_front());
            void'(bit_q2.pop_front());
            pos = (pos + 1) % W;
          end
        end
      end else begin
        check("idle_sout", sout, 0);
        check("idle_fs", frame_start, 0);
      end
      if (in_valid && in_ready)
        for (int i = 0; i < W; i++) begin
          bit_q.push_back(in_data[W-1-i]);
          bit_q2.push_back(in_data[i]);
        end
    end
  end
  always @(posedge clk) if (sout_valid && en) begin
    lb   <= {lb[W-2:0], sout};
    lb2  <= {sout2, lb2[W-1:1]};
    seq2 <= {seq2[W-2:0], sout2};
  end
  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 4'hF;
    step();
    mon_on = 1'b1;
    step();
    check("rst_sout", sout, 0);
    check("rst_valid", sout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1);
    en = 1'b1;
    send(4'b1011);
    step();
    check("lat_valid", sout_valid, 1);
    check("lat_fs", frame_start, 1);
    check("lat_sout", sout, 1);
    cnt = 0; fsn = 0;
    for (int i = 0; i < 6; i++) begin
      if (sout_valid) cnt++;
      if (frame_start) fsn++;
      step();
    end
    check("t2_len", cnt, 4);
    check("t2_fs", fsn, 1);
    check("t2_idle", sout, 0);
    send(4'hA);
    send(4'h5);
    cnt = 0;
    while (sout_valid && cnt < 20) begin
      cnt++;
      step();
    end
    check("t3_gapless", cnt, 7);
    en = 1'b0;
    send(4'hC);
    step();
    fsn = 0; vn = 0;
    for (int i = 0; i < 12; i++) begin
      en = (i % 3 == 2);
      if (frame_start) fsn++;
      if (sout_valid) vn++;
      step();
    end
    en = 1'b0;
    check("t4_fs_span", fsn, 3);
    check("t4_len", vn, 12);
    check("t4_done", sout_valid, 0);
    en = 1'b1;
    send(4'h9);
    send(4'h6);
    step();
    rst = 1'b1;
    step();
    check("t5_valid", sout_valid, 0);
    check("t5_busy", busy, 0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (sout_valid) n++;
      step();
    end
    check("t5_flushed", n, 0);
    send(4'h3);
    drain();
    send(4'hB);
    drain();
    check("t6_loop_msb", lb, 4'hB);
    check("t6_loop_lsb", lb2, 4'hB);
    check("t6_lsb_order", seq2, 4'b1101);
    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom % 2;
      in_data  = W'($urandom);
      en       = ($urandom % 10) < 7;
      rst      = ($urandom % 200) == 0;
      step();
    end
    rst = 1'b0; in_valid = 1'b0; en = 1'b1;
    drain();
    step();
    check("final_empty", bit_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
